// File: rtl/chess_pkg.sv
// Shared chess move-generation types: promo codes, side/state encodings, rank masks.
package chess_pkg;

  localparam int unsigned MAX_SQ = 256;

  typedef enum logic [2:0] {
    PROMO_NONE = 3'b000,
    PROMO_Q    = 3'b100,
    PROMO_R    = 3'b101,
    PROMO_B    = 3'b110,
    PROMO_N    = 3'b111
  } promo_e;

  typedef enum logic {
    SIDE_WHITE = 1'b0,
    SIDE_BLACK = 1'b1
  } side_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_EMIT,
    ST_DONE
  } state_e;

  typedef logic [MAX_SQ-1:0] wide_mask_t;

  // One bit per square of the given rank; callers truncate to their board size.
  function automatic wide_mask_t rank_mask(input int unsigned files, input int unsigned rank);
    wide_mask_t m;
    m = '0;
    for (int unsigned f = 0; f < files; f++) begin
      m[rank*files + f] = 1'b1;
    end
    return m;
  endfunction

  function automatic int unsigned double_rank(input side_e s, input int unsigned ranks);
    return (s == SIDE_WHITE) ? 32'd3 : ranks - 32'd4;
  endfunction

  function automatic int unsigned promo_rank(input side_e s, input int unsigned ranks);
    return (s == SIDE_WHITE) ? ranks - 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/lsb_index.sv
// Combinational lowest-set-bit index of a mask, plus a non-empty flag.
module lsb_index #(
  parameter int unsigned N = 64,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx_c,
  output logic         any_c
);

  always_comb begin
    idx_c = '0;
    any_c = |vec;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) idx_c = W'(i);
    end
  end

endmodule

// File: rtl/pawn_push_gen.sv
// Pawn single/double push generator: latches the board on start, then streams
// every legal push (singles first, then doubles) over a valid/ready handshake.
module pawn_push_gen
  import chess_pkg::*;
#(
  parameter int unsigned FILES        = 8,
  parameter int unsigned RANKS        = 8,
  parameter int unsigned PROMO_EXPAND = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           side,
  input  logic [FILES*RANKS-1:0]         occupied,
  input  logic [FILES*RANKS-1:0]         pawns,
  output logic                           busy,
  output logic [FILES*RANKS-1:0]         push_mask,
  output logic                           move_valid,
  input  logic                           move_ready,
  output logic [$clog2(FILES*RANKS)-1:0] move_from,
  output logic [$clog2(FILES*RANKS)-1:0] move_to,
  output logic                           move_double,
  output logic [2:0]                     move_promo,
  output logic                           move_last,
  output logic                           done
);

  localparam int unsigned N   = FILES * RANKS;
  localparam int unsigned SQW = $clog2(N);

  localparam logic [N-1:0]   WHITE_DBL = N'(rank_mask(FILES, double_rank(SIDE_WHITE, RANKS)));
  localparam logic [N-1:0]   BLACK_DBL = N'(rank_mask(FILES, double_rank(SIDE_BLACK, RANKS)));
  localparam logic [SQW-1:0] STEP1     = SQW'(FILES);
  localparam logic [SQW-1:0] STEP2     = SQW'(2 * FILES);
  localparam logic [SQW-1:0] W_PROMO   = SQW'(promo_rank(SIDE_WHITE, RANKS) * FILES);
  localparam bit             EXPAND    = (PROMO_EXPAND != 0);

  state_e state_q, state_d;

  logic [N-1:0]   occ_q, occ_d;
  logic [N-1:0]   pawns_q, pawns_d;
  side_e          side_q, side_d;
  logic [N-1:0]   single_q, single_d;
  logic [N-1:0]   double_q, double_d;
  logic [N-1:0]   push_mask_q, push_mask_d;
  logic [1:0]     promo_idx_q, promo_idx_d;
  logic           move_valid_q, move_valid_d;
  logic [SQW-1:0] move_from_q, move_from_d;
  logic [SQW-1:0] move_to_q, move_to_d;
  logic           move_double_q, move_double_d;
  logic [2:0]     move_promo_q, move_promo_d;
  logic           move_last_q, move_last_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [N-1:0]   calc_single_c, calc_double_c;
  logic           calc_any_c;
  logic           handshake_c, promo_step_c;
  logic [SQW-1:0] s_idx_c, d_idx_c;
  logic           s_any_c, d_any_c;
  logic           nxt_any_c, nxt_double_c, nxt_last_c, nxt_promotes_c;
  logic [SQW-1:0] nxt_from_c, nxt_to_c;
  logic [2:0]     nxt_promo_c;
  logic           s_multi_c, d_multi_c, more_promo_c;

  // Target masks from the latched board.
  always_comb begin
    if (side_q == SIDE_WHITE) begin
      calc_single_c = (pawns_q << FILES) & ~occ_q;
      calc_double_c = (calc_single_c << FILES) & ~occ_q & WHITE_DBL;
    end else begin
      calc_single_c = (pawns_q >> FILES) & ~occ_q;
      calc_double_c = (calc_single_c >> FILES) & ~occ_q & BLACK_DBL;
    end
    calc_any_c = |(calc_single_c | calc_double_c);
  end

  assign handshake_c  = (state_q == ST_EMIT) && move_valid_q && move_ready;
  assign promo_step_c = EXPAND && (move_promo_q != PROMO_NONE) && (move_promo_q != PROMO_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CALC;
      ST_CALC: state_d = calc_any_c ? ST_EMIT : ST_DONE;
      ST_EMIT: if (handshake_c && move_last_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending masks after this cycle; a promoting target keeps its bit until the N step.
  always_comb begin
    single_d    = single_q;
    double_d    = double_q;
    promo_idx_d = promo_idx_q;
    if (state_q == ST_CALC) begin
      single_d    = calc_single_c;
      double_d    = calc_double_c;
      promo_idx_d = '0;
    end else if (handshake_c) begin
      if (promo_step_c) begin
        promo_idx_d = promo_idx_q + 2'd1;
      end else begin
        promo_idx_d = '0;
        if (move_double_q) double_d = double_q & (double_q - N'(1));
        else               single_d = single_q & (single_q - N'(1));
      end
    end
  end

  lsb_index #(.N(N), .W(SQW)) u_lsb_single (.vec(single_d), .idx_c(s_idx_c), .any_c(s_any_c));
  lsb_index #(.N(N), .W(SQW)) u_lsb_double (.vec(double_d), .idx_c(d_idx_c), .any_c(d_any_c));

  // Move to offer next, derived from the post-update pending masks.
  always_comb begin
    nxt_any_c      = s_any_c | d_any_c;
    nxt_double_c   = !s_any_c;
    nxt_to_c       = s_any_c ? s_idx_c : d_idx_c;
    nxt_promotes_c = 1'b0;
    nxt_promo_c    = PROMO_NONE;
    if (side_q == SIDE_WHITE) begin
      nxt_from_c = nxt_to_c - (s_any_c ? STEP1 : STEP2);
      if (s_any_c) nxt_promotes_c = (s_idx_c >= W_PROMO);
    end else begin
      nxt_from_c = nxt_to_c + (s_any_c ? STEP1 : STEP2);
      if (s_any_c) nxt_promotes_c = (s_idx_c < STEP1);
    end
    if (nxt_promotes_c) nxt_promo_c = EXPAND ? {1'b1, promo_idx_d} : PROMO_Q;
    s_multi_c    = (single_d & (single_d - N'(1))) != '0;
    d_multi_c    = (double_d & (double_d - N'(1))) != '0;
    more_promo_c = nxt_promotes_c && EXPAND && (promo_idx_d != 2'd3);
    nxt_last_c   = !more_promo_c && (s_any_c ? (!s_multi_c && !d_any_c) : !d_multi_c);
  end

  always_comb begin
    occ_d         = occ_q;
    pawns_d       = pawns_q;
    side_d        = side_q;
    push_mask_d   = push_mask_q;
    move_valid_d  = move_valid_q;
    move_from_d   = move_from_q;
    move_to_d     = move_to_q;
    move_double_d = move_double_q;
    move_promo_d  = move_promo_q;
    move_last_d   = move_last_q;
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          occ_d   = occupied;
          pawns_d = pawns;
          side_d  = side_e'(side);
        end
      end
      ST_CALC: push_mask_d = calc_single_c | calc_double_c;
      ST_EMIT: begin
        if (handshake_c && move_last_q) begin
          move_valid_d = 1'b0;
          move_last_d  = 1'b0;
        end
      end
      default: ;
    endcase
    if ((state_q == ST_CALC) || (handshake_c && !move_last_q)) begin
      move_valid_d  = nxt_any_c;
      move_from_d   = nxt_from_c;
      move_to_d     = nxt_to_c;
      move_double_d = nxt_double_c;
      move_promo_d  = nxt_promo_c;
      move_last_d   = nxt_last_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q         <= '0;
      pawns_q       <= '0;
      side_q        <= SIDE_WHITE;
      single_q      <= '0;
      double_q      <= '0;
      push_mask_q   <= '0;
      promo_idx_q   <= '0;
      move_valid_q  <= 1'b0;
      move_from_q   <= '0;
      move_to_q     <= '0;
      move_double_q <= 1'b0;
      move_promo_q  <= PROMO_NONE;
      move_last_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      occ_q         <= occ_d;
      pawns_q       <= pawns_d;
      side_q        <= side_d;
      single_q      <= single_d;
      double_q      <= double_d;
      push_mask_q   <= push_mask_d;
      promo_idx_q   <= promo_idx_d;
      move_valid_q  <= move_valid_d;
      move_from_q   <= move_from_d;
      move_to_q     <= move_to_d;
      move_double_q <= move_double_d;
      move_promo_q  <= move_promo_d;
      move_last_q   <= move_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign busy        = busy_q;
  assign push_mask   = push_mask_q;
  assign move_valid  = move_valid_q;
  assign move_from   = move_from_q;
  assign move_to     = move_to_q;
  assign move_double = move_double_q;
  assign move_promo  = move_promo_q;
  assign move_last   = move_last_q;
  assign done        = done_q;

endmodule
